writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage. Accepts retiring instructions from the memory stage and produces the write port of the 32x32 register file: rf_wr_addr, rf_data and rf_write_enable.
- For loads, it waits for the variable-latency data memory response, then byte/halfword-extracts and sign/zero-extends the returned word before writing it back.
- It also counts retired instructions and flags loads whose response times out.

Parameters:
- LOAD_TIMEOUT, 16: maximum number of cycles spent in WAIT_LOAD before the load is abandoned. Legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  memory stage presents a retiring instruction
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready
- in_rd  in  5  destination register index
- in_reg_write  in  1  instruction writes a register
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  in  2  load byte offset (effective address [1:0])
- in_alu_result  in  32  result for non-load instructions
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word
- rf_wr_addr  out  5  register file write address (registered)
- rf_data  out  32  register file write data (registered)
- rf_write_enable  out  1  register file write strobe, one-cycle pulse (registered)
- load_err  out  1  one-cycle pulse when a load times out (registered)
- retire_cnt  out  32  retired instruction count (registered)

Behaviour:
- Reset: while rst=1 at a rising edge:
  - state <- IDLE; timer <- 0.
  - rf_wr_addr, rf_data, rf_write_enable, load_err, retire_cnt <- 0.
  - in_ready = 0 while rst is high.
- in_ready is combinational: (state==IDLE) && !rst.
- IDLE, transfer with in_is_load=0 (edge N):
  - At edge N, rf_wr_addr <- in_rd and rf_data <- in_alu_result.
  - rf_write_enable <- in_reg_write && (in_rd != 0), high for exactly the cycle after N.
  - retire_cnt increments. State stays IDLE, so back-to-back accepts give one pulse per instruction.
- IDLE, transfer with in_is_load=1:
  - Latch in_rd, in_reg_write, in_funct3, in_addr_lo; timer <- 0; state <- WAIT_LOAD.
  - No write. mem_rvalid is ignored in the accept cycle and at any time outside WAIT_LOAD.
- WAIT_LOAD, mem_rvalid=1:
  - rf_data <- extended value; rf_wr_addr <- latched rd.
  - rf_write_enable <- latched reg_write && rd != 0.
  - retire_cnt increments; state <- IDLE.
  - Latency is 1 cycle from the rvalid edge to the write pulse.
- WAIT_LOAD, mem_rvalid=0, timer < LOAD_TIMEOUT-1: timer increments.
- WAIT_LOAD, mem_rvalid=0, timer == LOAD_TIMEOUT-1:
  - load_err pulses for one cycle; no write; retire_cnt unchanged; state <- IDLE.
  - The load stays in WAIT_LOAD for exactly LOAD_TIMEOUT cycles before abandonment.
  - If mem_rvalid=1 in that final cycle, the data wins: normal write, no error.
- Extraction and extension:
  - LB/LBU: byte = mem_rdata[8*addr_lo +: 8]; sign- or zero-extend to 32 bits.
  - LH/LHU: half = mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] ignored; sign- or zero-extend.
  - LW: full word; addr_lo ignored.
  - funct3 011, 110, 111: treated as LW. No misalignment detection.
- Hold behaviour: when no write occurs, rf_wr_addr and rf_data hold their last values; rf_write_enable and load_err are 0.
- x0 protection: writes to rd=0 are never strobed, but the instruction still counts as retired.
- retire_cnt wraps from 0xFFFFFFFF to 0.
- rst asserted during WAIT_LOAD abandons the load: no write, no load_err.

Test Plan:
- Reset, then ALU op rd=5, alu_result=0x1234_5678: one-cycle rf_write_enable with rf_wr_addr=5, rf_data=0x12345678 the cycle after acceptance; retire_cnt=1.
- Three back-to-back ALU ops (rd=1,2,0): pulses for rd=1 and rd=2 on consecutive cycles; no pulse for rd=0; retire_cnt=3; in_ready held high throughout.
- LB, addr_lo=3, rvalid 4 cycles later with mem_rdata=0x80FF_0000: write data 0xFFFFFF80; in_ready=0 during the wait. Same with LBU: 0x00000080. LH, addr_lo=2, same word: 0xFFFF80FF. LHU, addr_lo=0, mem_rdata=0x0000_8001: 0x00008001.
- LW with no rvalid, LOAD_TIMEOUT=16: load_err pulses exactly once, 16 cycles after acceptance; no write; retire_cnt unchanged; in_ready returns to 1. Repeat with rvalid in the 16th cycle: write occurs, no load_err.
- rst during WAIT_LOAD, then rvalid: no write, no load_err, outputs 0. Preload retire_cnt to 0xFFFFFFFF via 2^32-1 retires or force, then retire one ALU op: retire_cnt wraps to 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly and waits for the data memory
// response on loads, then extracts/extends and strobes the register-file write port.
//
// state     | meaning
// IDLE      | ready for the next retiring instruction
// WAIT_LOAD | load accepted; waiting for mem_rvalid or timeout
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_data,
  output logic        rf_write_enable,
  output logic        load_err,
  output logic [31:0] retire_cnt
);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [4:0]  ld_rd;
  logic        ld_reg_write;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_latch;

  logic [4:0]  wr_addr_nxt;
  logic [31:0] wr_data_nxt;
  logic        wr_en_nxt;
  logic        err_nxt;
  logic [31:0] cnt_nxt;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // Reserved load encodings fall through to a full-word load.
    case (ld_funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'h0, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'h0, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE) && !rst;
    state_nxt   = state;
    timer_nxt   = timer;
    ld_latch    = 1'b0;
    wr_addr_nxt = rf_wr_addr;
    wr_data_nxt = rf_data;
    wr_en_nxt   = 1'b0;
    err_nxt     = 1'b0;
    cnt_nxt     = retire_cnt;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_is_load) begin
            ld_latch  = 1'b1;
            timer_nxt = 8'd0;
            state_nxt = WAIT_LOAD;
          end else begin
            wr_addr_nxt = in_rd;
            wr_data_nxt = in_alu_result;
            wr_en_nxt   = in_reg_write && (in_rd != 5'd0);
            cnt_nxt     = retire_cnt + 32'd1;
          end
        end
      end
      WAIT_LOAD: begin
        // Data arriving in the final cycle takes priority over the timeout.
        if (mem_rvalid) begin
          wr_addr_nxt = ld_rd;
          wr_data_nxt = ld_value;
          wr_en_nxt   = ld_reg_write && (ld_rd != 5'd0);
          cnt_nxt     = retire_cnt + 32'd1;
          state_nxt   = IDLE;
        end else if (timer == TIMER_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= 8'd0;
      ld_rd           <= 5'd0;
      ld_reg_write    <= 1'b0;
      ld_funct3       <= 3'd0;
      ld_addr_lo      <= 2'd0;
      rf_wr_addr      <= 5'd0;
      rf_data         <= 32'd0;
      rf_write_enable <= 1'b0;
      load_err        <= 1'b0;
      retire_cnt      <= 32'd0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      rf_wr_addr      <= wr_addr_nxt;
      rf_data         <= wr_data_nxt;
      rf_write_enable <= wr_en_nxt;
      load_err        <= err_nxt;
      retire_cnt      <= cnt_nxt;
      if (ld_latch) begin
        ld_rd        <= in_rd;
        ld_reg_write <= in_reg_write;
        ld_funct3    <= in_funct3;
        ld_addr_lo   <= in_addr_lo;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed plan items plus randomized
// ALU/load traffic checked against an arithmetic reference model.
module tb_writeback_stage;

  localparam int LOAD_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_data;
  logic        rf_write_enable;
  logic        load_err;
  logic [31:0] retire_cnt;

  writeback_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_wr_addr(rf_wr_addr),
    .rf_data(rf_data), .rf_write_enable(rf_write_enable), .load_err(load_err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 32'd0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result from plain arithmetic on the returned word.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    int unsigned v;
    int unsigned sh;
    case (f3)
      3'b000, 3'b100: begin
        sh = 8 * int'(off);
        v  = (w >> sh) % 256;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        sh = 16 * (int'(off) / 2);
        v  = (w >> sh) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic push_write(input logic [4:0] rd, input logic [31:0] d);
    ev_t e;
    e.is_err = 1'b0; e.addr = rd; e.data = d; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1; e.addr = '0; e.data = '0; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per observed pulse.
  always @(negedge clk) begin
    if (mon_en && (rf_write_enable === 1'b1 || load_err === 1'b1)) begin
      ev_t e;
      if (rf_write_enable === 1'b1 && load_err === 1'b1) begin
        check("mon_both_pulses", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("mon_unexpected_pulse", {30'd0, load_err, rf_write_enable}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("mon_kind", {31'd0, load_err}, {31'd0, e.is_err});
        check("mon_retire_cnt", retire_cnt, e.cnt);
        if (!e.is_err) begin
          check("mon_wr_addr", {27'd0, rf_wr_addr}, {27'd0, e.addr});
          check("mon_wr_data", rf_data, e.data);
        end
      end
    end
  end

  task automatic go_idle();
    @(negedge clk);
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic rw, input logic [31:0] d);
    @(negedge clk);
    check("ready_alu", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_rd         = rd;
    in_reg_write  = rw;
    in_alu_result = d;
    in_funct3     = 3'($urandom);
    in_addr_lo    = 2'($urandom);
    mem_rvalid    = 1'($urandom);
    mem_rdata     = $urandom;
    exp_cnt       = exp_cnt + 32'd1;
    if (rw && rd != 5'd0) push_write(rd, d);
    @(posedge clk);
  endtask

  // delay k: mem_rvalid is sampled at the k-th edge after acceptance;
  // k > LOAD_TIMEOUT means the response never comes in time.
  task automatic issue_load(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] w, input int delay);
    bit hit;
    bit strobe;
    hit    = (delay >= 1 && delay <= LOAD_TIMEOUT);
    strobe = hit && rw && rd != 5'd0;
    @(negedge clk);
    check("ready_load", {31'd0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    in_is_load   = 1'b1;
    in_rd        = rd;
    in_reg_write = rw;
    in_funct3    = f3;
    in_addr_lo   = off;
    in_alu_result = $urandom;
    mem_rvalid   = 1'($urandom);
    mem_rdata    = $urandom;
    if (hit) begin
      exp_cnt = exp_cnt + 32'd1;
      if (strobe) push_write(rd, model_load(f3, off, w));
    end else begin
      push_err();
    end
    @(posedge clk);
    for (int k = 1; k <= LOAD_TIMEOUT; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1 || k == LOAD_TIMEOUT) check("ready_in_wait", {31'd0, in_ready}, 32'd0);
      mem_rvalid = (k == delay);
      mem_rdata  = (k == delay) ? w : $urandom;
      @(posedge clk);
      if (k == delay) break;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("ready_after_load", {31'd0, in_ready}, 32'd1);
    check("load_strobe_latency", {31'd0, rf_write_enable}, {31'd0, strobe});
    check("load_err_latency", {31'd0, load_err}, {31'd0, !hit});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outputs", {26'd0, rf_write_enable, load_err, rf_wr_addr},  32'd0);
    check("rst_data", rf_data, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; in_alu_result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    do_reset();
    mon_en = 1'b1;

    issue_alu(5'd5, 1'b1, 32'h1234_5678);
    go_idle();
    check("alu_pulse", {31'd0, rf_write_enable}, 32'd1);
    check("alu_cnt", retire_cnt, 32'd1);
    @(negedge clk);
    check("alu_pulse_one_cycle", {31'd0, rf_write_enable}, 32'd0);
    check("hold_data", rf_data, 32'h1234_5678);

    issue_alu(5'd1, 1'b1, 32'hAAAA_0001);
    issue_alu(5'd2, 1'b1, 32'hBBBB_0002);
    issue_alu(5'd0, 1'b1, 32'hCCCC_0003);
    go_idle();
    check("b2b_no_x0_pulse", {31'd0, rf_write_enable}, 32'd0);
    check("b2b_cnt", retire_cnt, 32'd4);

    issue_load(5'd3, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 4);
    check("lb_data", rf_data, 32'hFFFF_FF80);
    issue_load(5'd4, 1'b1, 3'b100, 2'd3, 32'h80FF_0000, 4);
    check("lbu_data", rf_data, 32'h0000_0080);
    issue_load(5'd6, 1'b1, 3'b001, 2'd2, 32'h80FF_0000, 4);
    check("lh_data", rf_data, 32'hFFFF_80FF);
    issue_load(5'd7, 1'b1, 3'b101, 2'd0, 32'h0000_8001, 4);
    check("lhu_data", rf_data, 32'h0000_8001);

    issue_load(5'd8, 1'b1, 3'b010, 2'd1, 32'hDEAD_BEEF, 0);
    check("timeout_cnt_unchanged", retire_cnt, exp_cnt);
    @(negedge clk);
    check("err_one_cycle", {31'd0, load_err}, 32'd0);
    issue_load(5'd9, 1'b1, 3'b010, 2'd1, 32'hDEAD_BEEF, LOAD_TIMEOUT);
    check("last_cycle_data_wins", rf_data, 32'hDEAD_BEEF);

    // Reset while waiting: the late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd10; in_reg_write = 1'b1;
    in_funct3 = 3'b010; in_addr_lo = 2'd0; mem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    exp_cnt = 32'd0;
    check("rst_wait_outputs", {26'd0, rf_write_enable, load_err, rf_wr_addr}, 32'd0);
    check("rst_wait_data", rf_data, 32'd0);
    check("rst_wait_cnt", retire_cnt, 32'd0);

    @(negedge clk);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    issue_alu(5'd11, 1'b1, 32'h0BAD_F00D);
    go_idle();
    check("cnt_wrap", retire_cnt, 32'd0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        issue_alu(5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
        if ($urandom_range(0, 2) == 0) go_idle();
      end else begin
        issue_load(5'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom), 2'($urandom),
                   $urandom, $urandom_range(1, LOAD_TIMEOUT + 2));
      end
    end
    go_idle();
    repeat (3) @(negedge clk);
    check("final_cnt", retire_cnt, exp_cnt);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
